// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port instruction/data RAM between the IF and MEM pipeline
// stages. A request is granted only while the arbiter is idle; the address,
// write enable and store data are latched at the grant, held on the RAM pins
// for MEM_LATENCY cycles, and the read word is captured on the last busy
// cycle. The granted port then sees a one-cycle ready pulse.
//
// Handshake: a stage raises x_req and keeps it high until it sees x_ready.
// x_ready is a single-cycle pulse that means "your transaction is complete"
// (read data valid on x_rdata for fetches and loads). During the ready cycle
// the same port is not eligible for a new grant, so a request still held
// high in that cycle is not mistaken for a second access.
//
// Parameters
//   MEM_LATENCY   RAM cycles per access (1..7)
//   STARVE_LIMIT  MEM wins over a waiting IF at most this many times (1..3)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   if_req, if_addr         fetch request and byte address
//   mem_req, mem_we         load/store request, 1 = store
//   mem_addr, mem_wdata     data byte address and store data
//   ram_rdata               RAM read data, valid in the last busy cycle
//   if_ready, if_rdata      fetch done pulse and registered fetched word
//   mem_ready, mem_rdata    load/store done pulse and registered load word
//   ram_en, ram_we          RAM enable / write enable (busy states only)
//   ram_addr, ram_wdata     latched address / store data
//   addr_sel                external address mux select, 0 = IF, 1 = MEM
//   dbg_state               FSM state: 0 = IDLE, 1 = BUSY_IF, 2 = BUSY_MEM

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] ram_rdata,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        addr_sel,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [1:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        sel_q, sel_d;
  logic        if_ready_q, if_ready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic if_elig;
  logic mem_elig;
  logic force_if;

  // A port in its ready cycle is masked so its still-high request is not
  // granted a second time; the other port may be granted in that cycle.
  assign if_elig  = if_req && !if_ready_q;
  assign mem_elig = mem_req && !mem_ready_q;
  // After STARVE_LIMIT MEM wins against a requesting IF, IF takes priority.
  assign force_if = if_elig && (starve_q == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      sel_q       <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    sel_d       = sel_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_elig && !force_if) begin
          state_d = ST_BUSY_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_we;
          sel_d   = 1'b1;
          lat_d   = LAT_LOAD;
          // Count MEM wins while a fetch is pending; saturate at the limit.
          if (if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 2'd1;
          end
        end else if (if_elig) begin
          state_d  = ST_BUSY_IF;
          addr_d   = if_addr;
          wdata_d  = mem_wdata;
          we_d     = 1'b0;
          sel_d    = 1'b0;
          lat_d    = LAT_LOAD;
          starve_d = 2'd0;
        end
      end

      ST_BUSY_IF: begin
        if (lat_q == 3'd0) begin
          state_d    = ST_IDLE;
          if_rdata_d = ram_rdata;
          if_ready_d = 1'b1;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      ST_BUSY_MEM: begin
        if (lat_q == 3'd0) begin
          state_d     = ST_IDLE;
          mem_ready_d = 1'b1;
          // Stores leave the load register untouched.
          if (!we_q) begin
            mem_rdata_d = ram_rdata;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_en    = (state_q != ST_IDLE);
  assign ram_we    = (state_q != ST_IDLE) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign addr_sel  = sel_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign dbg_state = state_q;

endmodule
